// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
//   Shared definitions for the APB requester:
//   - default bus widths and the decode upper address limit
//   - response error codes carried on rsp_err
//   - controller state encoding
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int DEF_DATA_WIDTH       = 8;
  localparam int DEF_ADDR_WIDTH       = 8;
  localparam int DEF_UPPER_ADDR_LIMIT = 200;

  // Response status codes
  localparam logic [1:0] ERR_OK  = 2'b00;  // transfer completed cleanly
  localparam logic [1:0] ERR_SLV = 2'b01;  // slave flagged pslverr
  localparam logic [1:0] ERR_TMO = 2'b10;  // no pready within the timeout
  localparam logic [1:0] ERR_DEC = 2'b11;  // address outside the mapped range

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_slave_decode.sv
// ---------------------------------------------------------------------------
// apb_slave_decode
//   Purely combinational address decoder. The slave index is taken from the
//   top log2(NUM_SLAVES) address bits; addresses at or above UPPER_ADDR_LIMIT
//   are flagged as a decode error.
//
//   addr_i     in  ADDR_WIDTH   command address
//   sel_o      out NUM_SLAVES   one-hot select for the addressed slave
//   idx_o      out IDX_W        binary slave index
//   dec_err_o  out 1            address is outside the mapped range
// ---------------------------------------------------------------------------
module apb_slave_decode
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int NUM_SLAVES       = 2,
  parameter int UPPER_ADDR_LIMIT = DEF_UPPER_ADDR_LIMIT,
  parameter int IDX_W            = $clog2(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  dec_err_o
);

  // Compare in a width wide enough for both the address and the limit so a
  // limit that does not fit in ADDR_WIDTH bits is not silently truncated.
  localparam int CMP_W = ADDR_WIDTH + 32;

  assign idx_o     = addr_i[ADDR_WIDTH-1 -: IDX_W];
  assign dec_err_o = CMP_W'(addr_i) >= CMP_W'(UPPER_ADDR_LIMIT);

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
    assign sel_o[gi] = (idx_o == IDX_W'(gi));
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// apb_master_ctrl
//   APB requester. Takes one read/write command at a time on a valid/ready
//   port, runs IDLE -> SETUP -> ACCESS toward the addressed slave, honours
//   pready wait states with an optional timeout, and returns read data plus
//   status on a valid/ready response port.
//
//   pclk, preset         clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready is combinational)
//   cmd_write/addr/wdata command direction, address, write data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata, rsp_err   read data (0 for writes/errors) and status code
//   psel, penable, pwrite, paddr, pwdata     APB request side
//   prdata, pready, pslverr                  per-slave APB return side
// ---------------------------------------------------------------------------
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int NUM_SLAVES       = 2,
  parameter int UPPER_ADDR_LIMIT = DEF_UPPER_ADDR_LIMIT,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_err,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int IDX_W = $clog2(NUM_SLAVES);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value during the final permitted ACCESS cycle.
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_e state_q, state_d;

  logic [NUM_SLAVES-1:0] psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic                  pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic [IDX_W-1:0]      idx_q,       idx_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;

  logic [DATA_WIDTH-1:0] prdata_arr [NUM_SLAVES];

  apb_slave_decode #(
    .ADDR_WIDTH       (ADDR_WIDTH),
    .NUM_SLAVES       (NUM_SLAVES),
    .UPPER_ADDR_LIMIT (UPPER_ADDR_LIMIT),
    .IDX_W            (IDX_W)
  ) u_decode (
    .addr_i    (cmd_addr),
    .sel_o     (dec_sel),
    .idx_o     (dec_idx),
    .dec_err_o (dec_err)
  );

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_prdata
    assign prdata_arr[gi] = prdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // IDLE is the only accept point; reset masks it so no command is taken on
  // an edge that the reset is about to override.
  assign cmd_ready = (state_q == IDLE) && !preset;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    idx_d       = idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          idx_d    = dec_idx;
          cnt_d    = '0;
          if (dec_err) begin
            // Out-of-range address: answer immediately, no APB activity.
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = ERR_DEC;
            state_d     = RESP;
          end else begin
            psel_d  = dec_sel;
            state_d = SETUP;
          end
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (pready[idx_q]) begin
          // Read data is only meaningful for a clean read.
          rsp_rdata_d = (!pwrite_q && !pslverr[idx_q]) ? prdata_arr[idx_q] : '0;
          rsp_err_d   = pslverr[idx_q] ? ERR_SLV : ERR_OK;
          rsp_valid_d = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = ERR_TMO;
          rsp_valid_d = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_apb_master_ctrl
//   Directed bench for apb_master_ctrl with default parameters. A transaction
//   model predicts every output cycle by cycle from the protocol timeline;
//   a negedge process compares DUT against it. A simple slave model with
//   configurable wait states and error answers the APB side.
// ---------------------------------------------------------------------------
module tb_apb_master_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int NS  = 2;
  localparam int LIM = 200;
  localparam int TMO = 16;

  logic           pclk;
  logic           preset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_write;
  logic [AW-1:0]  cmd_addr;
  logic [DW-1:0]  cmd_wdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_rdata;
  logic [1:0]     rsp_err;
  logic [NS-1:0]  psel;
  logic           penable;
  logic           pwrite;
  logic [AW-1:0]  paddr;
  logic [DW-1:0]  pwdata;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0]  pready;
  logic [NS-1:0]  pslverr;

  apb_master_ctrl #(
    .DATA_WIDTH       (DW),
    .ADDR_WIDTH       (AW),
    .NUM_SLAVES       (NS),
    .UPPER_ADDR_LIMIT (LIM),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  int            slv_wait = 0;   // ACCESS cycles of pready low; <0 = never ready
  logic          slv_err  = 1'b0;
  int            acc_cnt  = 0;
  logic [DW-1:0] slave_mem [256];

  always_comb begin
    pready  = '0;
    pslverr = '0;
    prdata  = '0;
    for (int s = 0; s < NS; s++) begin
      if (psel[s]) begin
        pready[s]  = penable && (slv_wait >= 0) && (acc_cnt == slv_wait);
        pslverr[s] = slv_err;
        prdata[s*DW +: DW] = slave_mem[paddr];
      end else begin
        // Unselected slaves answer loudly; the DUT must ignore them.
        pready[s]  = 1'b1;
        pslverr[s] = 1'b1;
        prdata[s*DW +: DW] = 8'hEE;
      end
    end
  end

  always @(posedge pclk) begin
    acc_cnt <= penable ? acc_cnt + 1 : 0;
    if (penable && |(psel & pready) && pwrite && !slv_err)
      slave_mem[paddr] <= pwdata;
  end

  // ---------------- expected-output model ----------------
  logic [NS-1:0] m_psel;
  logic          m_penable, m_pwrite, m_rsp_valid, m_cmd_ready;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata, m_rsp_rdata;
  logic [1:0]    m_rsp_err;
  logic [DW-1:0] ref_mem [int];
  logic          chk_en = 1'b0;

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(m_cmd_ready));
      chk("psel",      32'(psel),      32'(m_psel));
      chk("penable",   32'(penable),   32'(m_penable));
      chk("pwrite",    32'(pwrite),    32'(m_pwrite));
      chk("paddr",     32'(paddr),     32'(m_paddr));
      chk("pwdata",    32'(pwdata),    32'(m_pwdata));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
      if (m_rsp_valid) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rsp_rdata));
        chk("rsp_err",   32'(rsp_err),   32'(m_rsp_err));
      end
    end
  end

  // Measurements pinned by literal expectations.
  int            lat = 0;
  logic          lat_run = 1'b0;
  int            pen_cnt = 0;
  logic [DW-1:0] cap_rdata;
  logic [1:0]    cap_err;

  always @(negedge pclk) begin
    if (penable) pen_cnt++;
    if (lat_run) begin
      lat++;
      if (rsp_valid) begin
        lat_run   = 1'b0;
        cap_rdata = rsp_rdata;
        cap_err   = rsp_err;
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One complete command/response exchange; the model timeline is derived
  // from the protocol: accept, one SETUP cycle, wait+1 ACCESS cycles (capped
  // by the timeout), then a response held for 'hold' cycles before consumption.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int wait_n,
                         input logic serr, input int hold);
    int   idx;
    int   n_acc;
    logic dec;
    idx = int'(addr) / (256 / NS);
    dec = int'(addr) >= LIM;
    slv_wait  = wait_n;
    slv_err   = serr;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    pen_cnt   = 0;
    tick();                         // accept edge
    cmd_valid   = 1'b0;
    lat         = 0;
    lat_run     = 1'b1;
    m_cmd_ready = 1'b0;
    m_paddr     = addr;
    m_pwrite    = wr;
    m_pwdata    = wdata;
    if (dec) begin
      m_rsp_valid = 1'b1;
      m_rsp_err   = 2'b11;
      m_rsp_rdata = '0;
    end else begin
      m_psel    = NS'(1 << idx);
      m_penable = 1'b0;
      tick();
      m_penable = 1'b1;
      n_acc = (wait_n < 0 || wait_n >= TMO) ? TMO : wait_n + 1;
      for (int i = 1; i < n_acc; i++) tick();
      tick();
      m_psel      = '0;
      m_penable   = 1'b0;
      m_rsp_valid = 1'b1;
      if (wait_n < 0 || wait_n >= TMO) begin
        m_rsp_err   = 2'b10;
        m_rsp_rdata = '0;
      end else begin
        m_rsp_err   = serr ? 2'b01 : 2'b00;
        m_rsp_rdata = (!wr && !serr) ? ref_mem[int'(addr)] : '0;
        if (wr && !serr) ref_mem[int'(addr)] = wdata;
      end
    end
    for (int i = 0; i < hold; i++) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready   = 1'b0;
    m_rsp_valid = 1'b0;
    m_cmd_ready = 1'b1;
    $display("txn wr=%0d addr=0x%02h wdata=0x%02h wait=%0d serr=%0d -> lat=%0d pen=%0d err=%0d rdata=0x%02h",
             wr, addr, wdata, wait_n, serr, lat, pen_cnt, cap_err, cap_rdata);
  endtask

  initial begin
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    m_psel = '0; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
    m_rsp_valid = 1'b0; m_rsp_rdata = '0; m_rsp_err = '0; m_cmd_ready = 1'b0;

    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_rdata", 32'(rsp_rdata), 32'h0);
    chk("reset_err",   32'(rsp_err),   32'h0);
    preset      = 1'b0;
    m_cmd_ready = 1'b1;
    tick();

    // Zero-wait write to slave 0
    run_txn(1'b1, 8'h33, 8'h88, 0, 1'b0, 0);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_penable_cycles", 32'(pen_cnt), 32'd1);
    chk("t1_err", 32'(cap_err), 32'd0);
    chk("t1_rdata", 32'(cap_rdata), 32'h0);

    // Read back
    run_txn(1'b0, 8'h33, 8'h00, 0, 1'b0, 0);
    chk("t2_rdata", 32'(cap_rdata), 32'h88);

    // Slave 1 with three wait states
    run_txn(1'b1, 8'h81, 8'h5A, 0, 1'b0, 1);
    run_txn(1'b0, 8'h81, 8'h00, 3, 1'b0, 0);
    chk("t3_access_cycles", 32'(pen_cnt), 32'd4);
    chk("t3_latency", 32'(lat), 32'd6);
    chk("t3_rdata", 32'(cap_rdata), 32'h5A);

    // Decode boundary: 199 is mapped, 200 is not
    run_txn(1'b1, 8'hC7, 8'h3C, 0, 1'b0, 0);
    run_txn(1'b0, 8'hC7, 8'h00, 1, 1'b0, 0);
    chk("t4_edge_rdata", 32'(cap_rdata), 32'h3C);
    run_txn(1'b0, 8'hC8, 8'h00, 0, 1'b0, 0);
    chk("t4_dec_latency", 32'(lat), 32'd1);
    chk("t4_dec_err", 32'(cap_err), 32'd3);
    chk("t4_dec_penable", 32'(pen_cnt), 32'd0);

    // Timeout, then slave error on a read with a stalled response port
    run_txn(1'b1, 8'h10, 8'h77, -1, 1'b0, 0);
    chk("t5_tmo_cycles", 32'(pen_cnt), 32'd16);
    chk("t5_tmo_err", 32'(cap_err), 32'd2);
    chk("t5_tmo_latency", 32'(lat), 32'd18);
    run_txn(1'b0, 8'h33, 8'h00, 2, 1'b1, 3);
    chk("t5_slv_err", 32'(cap_err), 32'd1);
    chk("t5_slv_rdata", 32'(cap_rdata), 32'h0);

    // Reset in the middle of ACCESS
    slv_wait  = -1;
    slv_err   = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h40;
    tick();
    cmd_valid = 1'b0;
    m_cmd_ready = 1'b0; m_paddr = 8'h40; m_pwrite = 1'b0; m_psel = 2'b01;
    tick();
    m_penable = 1'b1;
    tick();
    tick();
    preset = 1'b1;                  // cmd_ready drops combinationally
    tick();
    m_psel = '0; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
    m_rsp_valid = 1'b0;
    chk("t6_rst_rdata", 32'(rsp_rdata), 32'h0);
    chk("t6_rst_err", 32'(rsp_err), 32'h0);
    preset      = 1'b0;
    m_cmd_ready = 1'b1;
    tick();
    tick();
    $display("txn reset during ACCESS -> outputs cleared");

    // Recovery after reset
    run_txn(1'b0, 8'h33, 8'h00, 0, 1'b0, 0);
    chk("t6_recover_rdata", 32'(cap_rdata), 32'h88);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
